// File: rtl/sdc_block_tx_if.sv
// sdc_block_tx_if: handshake and serial bundle between the SD write-control
// FSM / write buffer (master side) and the block serialiser (slave side).
//   startCountData, count, byteEnable : control strobes from the write FSM
//   dataIn, empty                     : first-word-fall-through write buffer head
//   rdEn                              : buffer pop
//   mosi, sclkEn                      : serial bit and its SCLK gate
//   bytes, block, endCRC, busy        : phase-complete pulses and activity flag
interface sdc_block_tx_if;
    logic       startCountData;
    logic       count;
    logic       byteEnable;
    logic [7:0] dataIn;
    logic       empty;
    logic       rdEn;
    logic       mosi;
    logic       sclkEn;
    logic       bytes;
    logic       block;
    logic       endCRC;
    logic       busy;

    modport master (
        output startCountData, count, byteEnable, dataIn, empty,
        input  rdEn, mosi, sclkEn, bytes, block, endCRC, busy
    );

    modport slave (
        input  startCountData, count, byteEnable, dataIn, empty,
        output rdEn, mosi, sclkEn, bytes, block, endCRC, busy
    );
endinterface

// File: rtl/sdc_block_tx.sv
// sdc_block_tx: serialises one SD SPI-mode write data block onto MOSI:
// start token 0xFE, BLOCK_BYTES payload bytes popped from the write buffer,
// then CRC16-CCITT (poly 0x1021, init 0, MSB first) or 16'hFFFF.
// Ports:
//   clk      : system clock
//   resetAll : asynchronous active-high reset
//   bus      : sdc_block_tx_if.slave (strobes in, rdEn/mosi/sclkEn/pulses out)
module sdc_block_tx #(
    parameter int BLOCK_BYTES = 512,
    parameter int CRC_EN      = 1
) (
    input  logic           clk,
    input  logic           resetAll,
    sdc_block_tx_if.slave  bus
);
    localparam int BCW = $clog2(BLOCK_BYTES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {IDLE, TOKEN, DATA, CRC} state_t;

    state_t         state;
    logic [15:0]    shreg;
    logic [15:0]    crc;
    logic [3:0]     bitcnt;
    logic [BCW-1:0] bytecnt;
    logic           fetch_pend;
    logic           mosi_r, sclk_r, bytes_r, block_r, endcrc_r, busy_r;

    logic           fetch_ok, stall, step;
    logic [15:0]    cur;

    // Bytewise CRC16-CCITT update, MSB of the data byte first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    // At a byte boundary the fetch and the first shift of that byte share a
    // cycle, so the bitstream has no gap between bytes unless the buffer stalls.
    assign fetch_ok = bus.byteEnable && !bus.empty;
    assign stall    = (state == DATA) && fetch_pend && !fetch_ok;
    assign step     = (state != IDLE) && bus.count && !stall;
    assign bus.rdEn = (state == DATA) && fetch_pend && bus.count && fetch_ok;
    assign cur      = bus.rdEn ? {bus.dataIn, 8'h00} : shreg;

    always_ff @(posedge clk or posedge resetAll) begin
        if (resetAll) begin
            state      <= IDLE;
            shreg      <= 16'h0000;
            crc        <= 16'h0000;
            bitcnt     <= 4'd0;
            bytecnt    <= '0;
            fetch_pend <= 1'b0;
            mosi_r     <= 1'b1;
            sclk_r     <= 1'b0;
            bytes_r    <= 1'b0;
            block_r    <= 1'b0;
            endcrc_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            bytes_r  <= 1'b0;
            block_r  <= 1'b0;
            endcrc_r <= 1'b0;
            sclk_r   <= step;

            if (bus.rdEn)
                crc <= crc16_byte(crc, bus.dataIn);

            if (state == IDLE) begin
                mosi_r <= 1'b1;
                busy_r <= 1'b0;
                // endcrc_r high here means the block ended this very cycle;
                // a start strobe coinciding with it belongs to the old block.
                if (bus.startCountData && !endcrc_r) begin
                    state      <= TOKEN;
                    shreg      <= 16'hFE00;
                    crc        <= 16'h0000;
                    bitcnt     <= 4'd0;
                    bytecnt    <= '0;
                    fetch_pend <= 1'b0;
                    busy_r     <= 1'b1;
                end
            end else if (step) begin
                mosi_r     <= cur[15];
                shreg      <= {cur[14:0], 1'b0};
                bitcnt     <= bitcnt + 4'd1;
                fetch_pend <= 1'b0;
                case (state)
                    TOKEN: begin
                        if (bitcnt == 4'd7) begin
                            bytes_r    <= 1'b1;
                            bitcnt     <= 4'd0;
                            fetch_pend <= 1'b1;
                            state      <= DATA;
                        end
                    end
                    DATA: begin
                        if (bitcnt == 4'd7) begin
                            bitcnt  <= 4'd0;
                            bytecnt <= bytecnt + 1'b1;
                            if (bytecnt == LAST_BYTE) begin
                                // crc already holds the last byte: it was
                                // folded in at that byte's fetch, 7 steps ago.
                                block_r <= 1'b1;
                                shreg   <= (CRC_EN != 0) ? crc : 16'hFFFF;
                                state   <= CRC;
                            end else begin
                                fetch_pend <= 1'b1;
                            end
                        end
                    end
                    CRC: begin
                        if (bitcnt == 4'd15) begin
                            endcrc_r <= 1'b1;
                            bitcnt   <= 4'd0;
                            state    <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.mosi   = mosi_r;
    assign bus.sclkEn = sclk_r;
    assign bus.bytes  = bytes_r;
    assign bus.block  = block_r;
    assign bus.endCRC = endcrc_r;
    assign bus.busy   = busy_r;
endmodule

// File: tb/tb_sdc_block_tx.sv
// tb_sdc_block_tx: directed bench for sdc_block_tx. Three instances
// (9 bytes + CRC, 4 bytes + CRC, 4 bytes no CRC) share one stimulus set;
// sel picks which one receives startCountData and which is observed.
module tb_sdc_block_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetAll;
    logic       start, cnt, be, force_empty;
    logic [7:0] mem [0:15];
    int         ptr, nwr, sel;
    logic [7:0] din;
    logic       emp;

    assign din = mem[ptr[3:0]];
    assign emp = (ptr >= nwr) || force_empty;

    sdc_block_tx_if b9 ();
    sdc_block_tx_if b4 ();
    sdc_block_tx_if b4n ();

    assign b9.startCountData  = start && (sel == 0);
    assign b4.startCountData  = start && (sel == 1);
    assign b4n.startCountData = start && (sel == 2);
    assign b9.count  = cnt; assign b9.byteEnable  = be; assign b9.dataIn  = din; assign b9.empty  = emp;
    assign b4.count  = cnt; assign b4.byteEnable  = be; assign b4.dataIn  = din; assign b4.empty  = emp;
    assign b4n.count = cnt; assign b4n.byteEnable = be; assign b4n.dataIn = din; assign b4n.empty = emp;

    sdc_block_tx #(.BLOCK_BYTES(9), .CRC_EN(1)) u9  (.clk(clk), .resetAll(resetAll), .bus(b9.slave));
    sdc_block_tx #(.BLOCK_BYTES(4), .CRC_EN(1)) u4  (.clk(clk), .resetAll(resetAll), .bus(b4.slave));
    sdc_block_tx #(.BLOCK_BYTES(4), .CRC_EN(0)) u4n (.clk(clk), .resetAll(resetAll), .bus(b4n.slave));

    logic o_mosi, o_sclk, o_rd, o_bytes, o_block, o_end, o_busy;
    always_comb begin
        case (sel)
            0:       {o_mosi, o_sclk, o_rd, o_bytes, o_block, o_end, o_busy} =
                     {b9.mosi, b9.sclkEn, b9.rdEn, b9.bytes, b9.block, b9.endCRC, b9.busy};
            1:       {o_mosi, o_sclk, o_rd, o_bytes, o_block, o_end, o_busy} =
                     {b4.mosi, b4.sclkEn, b4.rdEn, b4.bytes, b4.block, b4.endCRC, b4.busy};
            default: {o_mosi, o_sclk, o_rd, o_bytes, o_block, o_end, o_busy} =
                     {b4n.mosi, b4n.sclkEn, b4n.rdEn, b4n.bytes, b4n.block, b4n.endCRC, b4n.busy};
        endcase
    end

    int checks, fails;

    // Observations of one block.
    bit   rx [0:255];
    int   nbits, nrd, nsclk, gaps, viol, overlap;
    int   n_bytes, n_block, n_end, pos_bytes, pos_block, pos_end, end_cyc;
    logic mosi_after, busy_after;

    function automatic logic [7:0] rxbyte(input int k);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], rx[8*k+i]};
        return b;
    endfunction

    // Reference CRC16-CCITT (XMODEM form): whole byte into the top, then 8 shifts.
    function automatic logic [15:0] crc_ref(input int n);
        logic [15:0] r;
        r = 16'h0000;
        for (int k = 0; k < n; k++) begin
            r = r ^ {mem[k], 8'h00};
            for (int i = 0; i < 8; i++) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    task automatic load4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d; nwr = 4; ptr = 0;
    endtask

    task automatic do_reset;
        @(negedge clk); resetAll = 1'b1; start = 1'b0;
        @(negedge clk); resetAll = 1'b0;
    endtask

    // Runs one block on instance s. Index c counts posedges after the one that
    // samples startCountData. tog halves the count duty; posedges
    // st_from..st_from+st_len-1 see an empty buffer; xs1/xs2 add start strobes.
    task automatic run_block(input int s, input bit tog, input int st_from, input int st_len,
                             input int xs1, input int xs2);
        bit   pop, end_seen;
        int   post;
        logic prev;
        sel = s; ptr = 0;
        nbits = 0; nrd = 0; nsclk = 0; gaps = 0; viol = 0; overlap = 0;
        n_bytes = 0; n_block = 0; n_end = 0; pos_bytes = -1; pos_block = -1; pos_end = -1;
        end_cyc = -1; mosi_after = 1'bx; busy_after = 1'bx;
        pop = 1'b0; end_seen = 1'b0; post = 0; prev = 1'b1;
        @(negedge clk); start = 1'b1; cnt = 1'b1; be = 1'b1; force_empty = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (pop) ptr++;
            start       = (c + 1 == xs1) || (c + 1 == xs2);
            cnt         = tog ? ((c + 1) % 2 == 0) : 1'b1;
            force_empty = (c + 1 >= st_from) && (c + 1 < st_from + st_len);
            @(negedge clk);
            pop = o_rd;
            if (o_rd) nrd++;
            if (force_empty && o_rd) viol++;
            if (!o_sclk && o_busy && o_mosi !== prev) viol++;
            if (!o_sclk && o_busy && nbits > 0) gaps++;
            if (o_sclk) begin
                if (nbits < 256) rx[nbits] = o_mosi;
                nbits++; nsclk++;
            end
            if (int'(o_bytes) + int'(o_block) + int'(o_end) > 1) overlap++;
            if (o_bytes) begin n_bytes++; pos_bytes = nbits; end
            if (o_block) begin n_block++; pos_block = nbits; end
            if (o_end)   begin n_end++;   pos_end = nbits; end_cyc = c; end_seen = 1'b1; end
            prev = o_mosi;
            if (end_seen && !o_end) begin
                post++;
                if (post == 1) begin mosi_after = o_mosi; busy_after = o_busy; end
                if (post == 3) break;
            end
        end
        start = 1'b0; force_empty = 1'b0; cnt = 1'b1;
    endtask

    task automatic test_reset;
        sel = 0;
        @(negedge clk); resetAll = 1'b1; #1;
        checks++; if (o_mosi !== 1'b1) begin fails++; $display("FAIL reset_mosi: got %b want 1", o_mosi); end
        checks++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if ({o_sclk, o_rd, o_bytes, o_block, o_end} !== 5'b0) begin
            fails++; $display("FAIL reset_outs: got %b want 00000", {o_sclk, o_rd, o_bytes, o_block, o_end}); end
        @(negedge clk); resetAll = 1'b0;
    endtask

    task automatic test_crc_vector;
        logic [7:0] e [0:11];
        e = '{8'hFE, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC3};
        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        nwr = 9;
        do_reset();
        run_block(0, 1'b0, -100, 0, -1, -1);
        checks++; if (nbits !== 96) begin fails++; $display("FAIL vec_nbits: got %0d want 96", nbits); end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (rxbyte(k) !== e[k]) begin fails++; $display("FAIL vec_byte%0d: got %h want %h", k, rxbyte(k), e[k]); end
        end
        checks++; if (nrd !== 9) begin fails++; $display("FAIL vec_rden: got %0d want 9", nrd); end
        checks++; if (n_bytes !== 1 || pos_bytes !== 8) begin fails++; $display("FAIL vec_bytes: got n=%0d at %0d want 1 at 8", n_bytes, pos_bytes); end
        checks++; if (n_block !== 1 || pos_block !== 80) begin fails++; $display("FAIL vec_block: got n=%0d at %0d want 1 at 80", n_block, pos_block); end
        checks++; if (n_end !== 1 || pos_end !== 96) begin fails++; $display("FAIL vec_end: got n=%0d at %0d want 1 at 96", n_end, pos_end); end
        checks++; if (gaps !== 0 || overlap !== 0 || viol !== 0) begin
            fails++; $display("FAIL vec_clean: gaps=%0d overlap=%0d viol=%0d want 0", gaps, overlap, viol); end
        checks++; if (mosi_after !== 1'b1 || busy_after !== 1'b0) begin
            fails++; $display("FAIL vec_idle: mosi=%b busy=%b want 1/0", mosi_after, busy_after); end
    endtask

    task automatic test_no_crc;
        logic [7:0] e [0:6];
        e = '{8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        load4(8'h00, 8'h00, 8'h00, 8'h00);
        do_reset();
        run_block(2, 1'b0, -100, 0, -1, -1);
        checks++; if (nsclk !== 56) begin fails++; $display("FAIL nocrc_sclk: got %0d want 56", nsclk); end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (rxbyte(k) !== e[k]) begin fails++; $display("FAIL nocrc_byte%0d: got %h want %h", k, rxbyte(k), e[k]); end
        end
        checks++; if (nrd !== 4) begin fails++; $display("FAIL nocrc_rden: got %0d want 4", nrd); end
    endtask

    task automatic check_stream4(input string tag);
        logic [15:0] c;
        logic [7:0]  e [0:6];
        c = crc_ref(4);
        e = '{8'hFE, mem[0], mem[1], mem[2], mem[3], c[15:8], c[7:0]};
        checks++; if (nbits !== 56) begin fails++; $display("FAIL %s_nbits: got %0d want 56", tag, nbits); end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (rxbyte(k) !== e[k]) begin fails++; $display("FAIL %s_byte%0d: got %h want %h", tag, k, rxbyte(k), e[k]); end
        end
        checks++; if (nrd !== 4) begin fails++; $display("FAIL %s_rden: got %0d want 4", tag, nrd); end
    endtask

    task automatic test_stall;
        load4(8'hA5, 8'h0F, 8'h80, 8'h01);
        do_reset();
        // Byte 2 would be fetched on posedge 25; hold the buffer empty for 5 edges.
        run_block(1, 1'b0, 25, 5, -1, -1);
        check_stream4("stall");
        checks++; if (gaps !== 5) begin fails++; $display("FAIL stall_gap: got %0d want 5", gaps); end
        checks++; if (viol !== 0) begin fails++; $display("FAIL stall_hold: got %0d violations want 0", viol); end
        checks++; if (end_cyc !== 61) begin fails++; $display("FAIL stall_len: got %0d want 61", end_cyc); end
    endtask

    task automatic test_toggle;
        load4(8'h5A, 8'hC3, 8'h7E, 8'h10);
        do_reset();
        run_block(1, 1'b1, -100, 0, -1, -1);
        check_stream4("toggle");
        checks++; if (end_cyc !== 112) begin fails++; $display("FAIL toggle_len: got %0d want 112", end_cyc); end
        checks++; if (n_bytes !== 1 || n_block !== 1 || n_end !== 1 || overlap !== 0) begin
            fails++; $display("FAIL toggle_pulses: got %0d/%0d/%0d ovl %0d want 1/1/1 ovl 0", n_bytes, n_block, n_end, overlap); end
        checks++; if (viol !== 0) begin fails++; $display("FAIL toggle_hold: got %0d violations want 0", viol); end
    endtask

    task automatic test_abort;
        bit pop;
        int k;
        load4(8'h11, 8'h22, 8'h33, 8'h44);
        do_reset();
        sel = 1; pop = 1'b0; k = 0;
        @(negedge clk); start = 1'b1; cnt = 1'b1; be = 1'b1; force_empty = 1'b0;
        for (int c = 0; c < 28; c++) begin
            @(posedge clk); #1;
            if (pop) ptr++;
            start = 1'b0;
            @(negedge clk);
            pop = o_rd;
            if (o_rd) k++;
        end
        checks++; if (k !== 3 || o_busy !== 1'b1) begin fails++; $display("FAIL abort_pre: got rd=%0d busy=%b want 3/1", k, o_busy); end
        resetAll = 1'b1; #1;
        checks++; if (o_mosi !== 1'b1 || o_busy !== 1'b0) begin
            fails++; $display("FAIL abort_now: mosi=%b busy=%b want 1/0", o_mosi, o_busy); end
        checks++; if ({o_sclk, o_rd, o_bytes, o_block, o_end} !== 5'b0) begin
            fails++; $display("FAIL abort_outs: got %b want 00000", {o_sclk, o_rd, o_bytes, o_block, o_end}); end
        @(negedge clk); resetAll = 1'b0;
        load4(8'h11, 8'h22, 8'h33, 8'h44);
        run_block(1, 1'b0, -100, 0, -1, -1);
        check_stream4("abort_fresh");
    endtask

    task automatic test_ignore_start;
        load4(8'hE7, 8'h01, 8'hFE, 8'h80);
        do_reset();
        // Extra strobes: posedge 3 (TOKEN) and posedge 57 (the endCRC cycle).
        run_block(1, 1'b0, -100, 0, 3, 57);
        check_stream4("ign");
        checks++; if (nsclk !== 56 || end_cyc !== 56) begin
            fails++; $display("FAIL ign_len: got sclk=%0d end=%0d want 56/56", nsclk, end_cyc); end
        checks++; if (busy_after !== 1'b0 || mosi_after !== 1'b1) begin
            fails++; $display("FAIL ign_idle: busy=%b mosi=%b want 0/1", busy_after, mosi_after); end
        load4(8'h3C, 8'h99, 8'h00, 8'hFF);
        run_block(1, 1'b0, -100, 0, -1, -1);
        check_stream4("ign_next");
    endtask

    initial begin
        checks = 0; fails = 0;
        resetAll = 1'b1; start = 1'b0; cnt = 1'b1; be = 1'b1; force_empty = 1'b0;
        sel = 0; ptr = 0; nwr = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        resetAll = 1'b0;
        test_reset();
        test_crc_vector();
        test_no_crc();
        test_stall();
        test_toggle();
        test_abort();
        test_ignore_start();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
